// File: rtl/boot_loader.sv
// Host byte-stream boot loader: parses load/run frames from the host, writes the
// assembled words into processor_top instruction/data memory, then releases the processor.
module boot_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] inst_data_in,
    output logic [31:0] inst_addr,
    output logic        inst_we,
    output logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic        proc_rst,
    input  logic        done,
    output logic        run_done,
    output logic        err
);
    localparam logic [7:0] CMD_INST = 8'h01;
    localparam logic [7:0] CMD_DATA = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;

    typedef enum logic [3:0] {
        IDLE, A_HI, A_LO, C_HI, C_LO, DATA, WRITE, RUN, HALT
    } state_t;

    state_t      state, state_nxt;
    logic        started;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] count;
    logic [31:0] word_acc;
    logic [1:0]  byte_idx;
    logic [31:0] inst_data_q, mem_data_q;
    logic [15:0] inst_addr_q, mem_addr_q;
    logic        take;
    logic        writing;

    // started keeps in_ready low until the first clock edge after reset release.
    assign in_ready = started && (state != WRITE) && (state != RUN) && (state != HALT);
    assign take     = in_valid && in_ready;
    assign proc_rst = (state != RUN) && (state != HALT);
    assign writing  = (state == WRITE);
    assign inst_we  = writing && (cmd == CMD_INST);
    assign mem_we   = writing && (cmd == CMD_DATA);

    // The live word/address are shown during WRITE; the _q copies hold them afterwards.
    assign inst_data_in = inst_we ? word_acc : inst_data_q;
    assign inst_addr    = {16'h0000, (inst_we ? addr : inst_addr_q)};
    assign mem_data_in  = mem_we ? word_acc : mem_data_q;
    assign mem_addr     = {16'h0000, (mem_we ? addr : mem_addr_q)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) begin
                    case (in_data)
                        CMD_INST, CMD_DATA: state_nxt = A_HI;
                        CMD_RUN:            state_nxt = RUN;
                        default:            state_nxt = IDLE;
                    endcase
                end
            end
            A_HI:  if (take) state_nxt = A_LO;
            A_LO:  if (take) state_nxt = C_HI;
            C_HI:  if (take) state_nxt = C_LO;
            C_LO: begin
                if (take) begin
                    state_nxt = ({count[15:8], in_data} != 16'h0000) ? DATA : IDLE;
                end
            end
            DATA:  if (take && (byte_idx == 2'd3)) state_nxt = WRITE;
            WRITE: state_nxt = (count == 16'd1) ? IDLE : DATA;
            RUN:   if (done) state_nxt = HALT;
            HALT:  state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started     <= 1'b0;
            run_done    <= 1'b0;
            err         <= 1'b0;
            cmd         <= 8'h00;
            addr        <= 16'h0000;
            count       <= 16'h0000;
            word_acc    <= 32'h0000_0000;
            byte_idx    <= 2'd0;
            inst_data_q <= 32'h0000_0000;
            inst_addr_q <= 16'h0000;
            mem_data_q  <= 32'h0000_0000;
            mem_addr_q  <= 16'h0000;
        end else begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (take) begin
                        cmd      <= in_data;
                        byte_idx <= 2'd0;
                        if ((in_data != CMD_INST) && (in_data != CMD_DATA) && (in_data != CMD_RUN)) begin
                            err <= 1'b1;
                        end
                    end
                end
                A_HI: if (take) addr[15:8]  <= in_data;
                A_LO: if (take) addr[7:0]   <= in_data;
                C_HI: if (take) count[15:8] <= in_data;
                C_LO: if (take) count[7:0]  <= in_data;
                DATA: begin
                    if (take) begin
                        word_acc <= {word_acc[23:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    if (inst_we) begin
                        inst_data_q <= word_acc;
                        inst_addr_q <= addr;
                    end
                    if (mem_we) begin
                        mem_data_q <= word_acc;
                        mem_addr_q <= addr;
                    end
                    addr  <= addr + 16'd1;
                    count <= count - 16'd1;
                end
                RUN: if (done) run_done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: per-cycle vector table for the frame scenarios,
// plus hand sequences for reset behaviour and the mid-frame reset.
module tb_boot_loader;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] inst_data_in;
    logic [31:0] inst_addr;
    logic        inst_we;
    logic [31:0] mem_data_in;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        proc_rst;
    logic        done;
    logic        run_done;
    logic        err;

    boot_loader dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .inst_data_in (inst_data_in),
        .inst_addr    (inst_addr),
        .inst_we      (inst_we),
        .mem_data_in  (mem_data_in),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .proc_rst     (proc_rst),
        .done         (done),
        .run_done     (run_done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {in_ready, inst_we, mem_we, proc_rst, err, run_done}
    localparam logic [5:0] RDY  = 6'b100100;
    localparam logic [5:0] RDE  = 6'b100110;
    localparam logic [5:0] WI   = 6'b010100;
    localparam logic [5:0] WM   = 6'b001100;
    localparam logic [5:0] RUNE = 6'b000010;
    localparam logic [5:0] HLTE = 6'b000011;
    localparam logic [5:0] RSTV = 6'b000100;

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        dn;
        logic [5:0]  ctrl;
        logic [15:0] addr;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_fail;

    task automatic add(input logic vld, input logic [7:0] d, input logic dn,
                       input logic [5:0] c, input logic [15:0] a, input logic [31:0] w);
        vec_t v;
        v.vld  = vld;
        v.data = d;
        v.dn   = dn;
        v.ctrl = c;
        v.addr = a;
        v.word = w;
        vecs.push_back(v);
    endtask

    task automatic b(input logic [7:0] d, input logic [5:0] c);
        add(1'b1, d, 1'b0, c, 16'h0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] d);
        @(negedge clk);
        chk("put_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = d;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctrl"}, {in_ready, inst_we, mem_we, proc_rst, err, run_done}, RSTV);
        chk({name, "_inst"}, {inst_addr, inst_data_in}, 64'h0);
        chk({name, "_mem"},  {mem_addr, mem_data_in}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        done     = 1'b0;

        // Scenario A: single instruction word at 0; done pulses outside RUN are ignored.
        b(8'h01, RDY); b(8'h00, RDY); b(8'h00, RDY);
        add(1'b1, 8'h00, 1'b1, RDY, 16'h0, 32'h0);
        b(8'h01, RDY); b(8'h20, RDY);
        add(1'b1, 8'h08, 1'b1, RDY, 16'h0, 32'h0);
        b(8'h00, RDY); b(8'h64, RDY);
        add(1'b0, 8'h00, 1'b1, WI, 16'h0000, 32'h2008_0064);
        add(1'b0, 8'h00, 1'b0, RDY, 16'h0, 32'h0);
        // Scenario B: two data words at 3,4; stall mid-header; byte held across WRITE.
        b(8'h02, RDY); b(8'h00, RDY);
        add(1'b0, 8'h00, 1'b0, RDY, 16'h0, 32'h0);
        b(8'h03, RDY); b(8'h00, RDY); b(8'h02, RDY);
        b(8'h00, RDY); b(8'h00, RDY); b(8'h00, RDY); b(8'h13, RDY);
        add(1'b1, 8'h00, 1'b0, WM, 16'h0003, 32'h0000_0013);
        b(8'h00, RDY); b(8'h00, RDY); b(8'h00, RDY); b(8'h09, RDY);
        add(1'b0, 8'h00, 1'b0, WM, 16'h0004, 32'h0000_0009);
        add(1'b0, 8'h00, 1'b0, RDY, 16'h0, 32'h0);
        // Scenario C: address wrap 0xFFFF -> 0x0000.
        b(8'h01, RDY); b(8'hFF, RDY); b(8'hFF, RDY); b(8'h00, RDY); b(8'h02, RDY);
        b(8'h11, RDY); b(8'h22, RDY); b(8'h33, RDY); b(8'h44, RDY);
        add(1'b0, 8'h00, 1'b0, WI, 16'hFFFF, 32'h1122_3344);
        b(8'h55, RDY); b(8'h66, RDY); b(8'h77, RDY); b(8'h88, RDY);
        add(1'b0, 8'h00, 1'b0, WI, 16'h0000, 32'h5566_7788);
        add(1'b0, 8'h00, 1'b0, RDY, 16'h0, 32'h0);
        // Scenario D: bad command, then an N=0 frame that writes nothing.
        b(8'h05, RDY);
        b(8'h01, RDE); b(8'h00, RDE); b(8'h00, RDE); b(8'h00, RDE); b(8'h00, RDE);
        add(1'b0, 8'h00, 1'b0, RDE, 16'h0, 32'h0);
        // Scenario E: run, done, then HALT ignores bytes and done.
        b(8'h03, RDE);
        add(1'b1, 8'h01, 1'b0, RUNE, 16'h0, 32'h0);
        add(1'b1, 8'h01, 1'b1, RUNE, 16'h0, 32'h0);
        add(1'b0, 8'h00, 1'b0, HLTE, 16'h0, 32'h0);
        add(1'b1, 8'h03, 1'b0, HLTE, 16'h0, 32'h0);
        add(1'b1, 8'h01, 1'b1, HLTE, 16'h0, 32'h0);
        add(1'b0, 8'h00, 1'b0, HLTE, 16'h0, 32'h0);

        repeat (2) @(negedge clk);
        chk_reset("reset_initial");
        rst = 1'b1;
        #1;
        chk("ready_before_first_edge", in_ready, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("ctrl[%0d]", i), {in_ready, inst_we, mem_we, proc_rst, err, run_done}, vecs[i].ctrl);
            if (vecs[i].ctrl[4])
                chk($sformatf("inst_bus[%0d]", i), {inst_addr, inst_data_in}, {16'h0, vecs[i].addr, vecs[i].word});
            if (vecs[i].ctrl[3])
                chk($sformatf("mem_bus[%0d]", i), {mem_addr, mem_data_in}, {16'h0, vecs[i].addr, vecs[i].word});
            in_valid = vecs[i].vld;
            in_data  = vecs[i].data;
            done     = vecs[i].dn;
        end
        done = 1'b0;

        chk("hold_inst", {inst_addr, inst_data_in}, {32'h0000_0000, 32'h5566_7788});
        chk("hold_mem",  {mem_addr, mem_data_in},   {32'h0000_0004, 32'h0000_0009});

        // Asynchronous reset from HALT clears everything immediately.
        #2 rst = 1'b0;
        #1 chk_reset("reset_from_halt");
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;

        // Reset after two payload bytes of a data frame.
        put(8'h02); put(8'h00); put(8'h10); put(8'h00); put(8'h01);
        put(8'hAA); put(8'hBB);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hCC;
        #2 rst = 1'b0;
        #1 chk_reset("reset_mid_frame");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("held_in_reset[%0d]", k), {in_ready, mem_we, inst_we}, 3'b000);
        end
        rst      = 1'b1;
        in_valid = 1'b0;

        put(8'h02); put(8'h00); put(8'h10); put(8'h00); put(8'h01);
        put(8'hCC); put(8'hDD); put(8'hEE); put(8'hFF);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fresh_strobe", {in_ready, inst_we, mem_we}, 3'b001);
        chk("fresh_mem_bus", {mem_addr, mem_data_in}, {32'h0000_0010, 32'hCCDD_EEFF});
        @(negedge clk);
        chk("fresh_after", {in_ready, inst_we, mem_we}, 3'b100);
        chk("fresh_hold", {mem_addr, mem_data_in}, {32'h0000_0010, 32'hCCDD_EEFF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
